// File: rtl/ofm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ofm_pkg
//  Description : Shared types and helpers for the output-feature-map bank
//                buffer: drain FSM states, lane write modes and the lane
//                bit-position helper used to slice packed words.
//  Revision    : 1.0  initial release
// ============================================================================
package ofm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } ofm_state_e;

    typedef enum logic {
        OVERWRITE = 1'b0,
        ACCUM     = 1'b1
    } ofm_mode_e;

    // LSB position of a lane inside a packed word. Lane 0 sits in the MSBs,
    // so the offset counts down from the top of the word.
    function automatic int lane_lsb(input int lane, input int lanes, input int data_w);
        return (lanes - 1 - lane) * data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofm_lane_sat.sv
`default_nettype none
// ============================================================================
//  Module      : ofm_lane_sat
//  Description : Combinational unsigned saturating adder for one lane. The old
//                operand is gated to zero when the lane has never been written,
//                so accumulation into a fresh lane starts from zero.
//  Ports       : old_i        stored lane value
//                old_valid_i  stored lane holds valid data
//                add_i        incoming addend
//                sum_o        min(old + add, 2^DATA_W-1)
//  Revision    : 1.0  initial release
// ============================================================================
module ofm_lane_sat #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] old_i,
    input  logic              old_valid_i,
    input  logic [DATA_W-1:0] add_i,
    output logic [DATA_W-1:0] sum_o
);

    logic [DATA_W-1:0] w_old;
    logic [DATA_W:0]   w_sum;

    assign w_old = old_valid_i ? old_i : '0;
    assign w_sum = {1'b0, w_old} + {1'b0, add_i};

    // Carry out means the true sum exceeds the lane range: clamp to all ones.
    assign sum_o = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/ofm_bank_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ofm_bank_buffer
//  Description : Output-feature-map buffer for one processing thread. Packs
//                lane results into DEPTH words of LANES x DATA_W by overwrite
//                or saturating accumulate, tracks per-lane fill state and the
//                number of fully populated words, and drains all words in
//                address order over a valid/ready stream.
//  Ports       : clock_i / reset_n_i      clock, async active-low reset
//                wr_*_i                   single-lane write request
//                wr_err_o                 pulse: previous write was dropped
//                words_complete_o         count of words with all lanes valid
//                drain_start_i            request a full drain
//                busy_o                   drain in progress
//                dout_*                   valid/ready output stream
//                drain_done_o             pulse after last handshake
//  Revision    : 1.0  initial release
// ============================================================================
module ofm_bank_buffer
    import ofm_pkg::*;
#(
    parameter  int DATA_W         = 8,
    parameter  int LANES          = 4,
    parameter  int DEPTH          = 128,
    parameter  int ADDR_W         = $clog2(DEPTH),
    parameter  int N_TH           = 0,
    parameter  int CLEAR_ON_DRAIN = 1,
    localparam int LANE_W         = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int WORD_W         = LANES * DATA_W
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W:0]   wr_addr_i,
    input  logic [LANE_W-1:0] wr_lane_i,
    input  logic              wr_mode_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_err_o,
    output logic [ADDR_W:0]   words_complete_o,
    input  logic              drain_start_i,
    output logic              busy_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic [WORD_W-1:0] dout_data_o,
    output logic [ADDR_W-1:0] dout_addr_o,
    output logic [7:0]        dout_tag_o,
    output logic              drain_done_o
);

    localparam logic [ADDR_W:0]   c_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    ofm_state_e state_q, state_d;

    logic [WORD_W-1:0] mem_q   [DEPTH];
    logic [LANES-1:0]  valid_q [DEPTH];
    logic [ADDR_W:0]   words_complete_q;

    logic              dout_valid_q;
    logic [WORD_W-1:0] dout_data_q;
    logic [ADDR_W-1:0] dout_addr_q;
    logic              wr_err_q;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_wa;
    logic              w_wr_ok;
    logic              w_wr_drop;
    logic [WORD_W-1:0] w_old_row;
    logic [LANES-1:0]  w_old_vrow;
    logic [DATA_W-1:0] w_old_lane;
    logic              w_old_lane_v;
    logic [DATA_W-1:0] w_sat;
    logic [DATA_W-1:0] w_new_lane;
    logic [WORD_W-1:0] w_wr_row;
    logic [LANES-1:0]  w_wr_vrow;
    logic              w_completes;

    assign w_wa      = wr_addr_i[ADDR_W-1:0];
    // The extra address bit lets out-of-range requests be caught here
    // instead of silently aliasing onto a low word.
    assign w_wr_ok   = wr_en_i && (state_q == IDLE) && (wr_addr_i < c_DEPTH);
    assign w_wr_drop = wr_en_i && !w_wr_ok;

    always_comb begin
        w_old_row    = mem_q[w_wa];
        w_old_vrow   = valid_q[w_wa];
        w_old_lane   = w_old_row[lane_lsb(int'(wr_lane_i), LANES, DATA_W) +: DATA_W];
        w_old_lane_v = w_old_vrow[wr_lane_i];
    end

    ofm_lane_sat #(
        .DATA_W (DATA_W)
    ) u_lane_sat (
        .old_i       (w_old_lane),
        .old_valid_i (w_old_lane_v),
        .add_i       (wr_data_i),
        .sum_o       (w_sat)
    );

    always_comb begin
        w_new_lane = (ofm_mode_e'(wr_mode_i) == ACCUM) ? w_sat : wr_data_i;
        w_wr_row   = w_old_row;
        w_wr_row[lane_lsb(int'(wr_lane_i), LANES, DATA_W) +: DATA_W] = w_new_lane;
        w_wr_vrow  = w_old_vrow | (LANES'(1) << wr_lane_i);
        // Only the write that fills the last hole counts; rewrites of a
        // complete word leave the counter alone.
        w_completes = w_wr_ok && (&w_wr_vrow) && !(&w_old_vrow);
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    logic              w_hs;
    logic              w_load;
    logic              w_last_hs;
    logic [ADDR_W-1:0] w_load_addr;

    assign w_hs = dout_valid_q && dout_ready_i;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_load      = 1'b0;
        w_last_hs   = 1'b0;
        w_load_addr = '0;
        case (state_q)
            IDLE: begin
                if (drain_start_i) begin
                    state_d     = DRAIN;
                    w_load      = 1'b1;
                    w_load_addr = '0;
                end
            end
            DRAIN: begin
                if (w_hs) begin
                    if (dout_addr_q == c_LAST_ADDR) begin
                        state_d   = DONE;
                        w_last_hs = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_load_addr = dout_addr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output word fetch. A write accepted in the drain_start cycle lands in
    // the array at the same edge that word 0 is loaded, so the merged row is
    // forwarded to keep that write visible in the stream.
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] w_src_row;
    logic [LANES-1:0]  w_src_vrow;
    logic [WORD_W-1:0] w_load_word;

    always_comb begin
        w_src_row  = mem_q[w_load_addr];
        w_src_vrow = valid_q[w_load_addr];
        if (w_wr_ok && (w_wa == w_load_addr)) begin
            w_src_row  = w_wr_row;
            w_src_vrow = w_wr_vrow;
        end
        // Array contents are not reset, so unwritten lanes are masked to 0.
        w_load_word = w_src_row;
        for (int l = 0; l < LANES; l++) begin
            if (!w_src_vrow[l]) begin
                w_load_word[lane_lsb(l, LANES, DATA_W) +: DATA_W] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (w_wr_ok) begin
            mem_q[w_wa] <= w_wr_row;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= '0;
            end
            words_complete_q <= '0;
        end else if ((state_q == DONE) && (CLEAR_ON_DRAIN != 0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= '0;
            end
            words_complete_q <= '0;
        end else if (w_wr_ok) begin
            valid_q[w_wa] <= w_wr_vrow;
            if (w_completes) begin
                words_complete_q <= words_complete_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_addr_q  <= '0;
            wr_err_q     <= 1'b0;
        end else begin
            wr_err_q <= w_wr_drop;
            if (w_load) begin
                dout_valid_q <= 1'b1;
                dout_data_q  <= w_load_word;
                dout_addr_q  <= w_load_addr;
            end else if (w_last_hs) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign wr_err_o         = wr_err_q;
    assign words_complete_o = words_complete_q;
    assign busy_o           = (state_q != IDLE);
    assign dout_valid_o     = dout_valid_q;
    assign dout_data_o      = dout_data_q;
    assign dout_addr_o      = dout_addr_q;
    assign dout_tag_o       = 8'(N_TH);
    assign drain_done_o     = (state_q == DONE);

endmodule
`default_nettype wire
